// File: rtl/led_blink_sched.sv
// LED blink scheduler: per-LED OFF/ON/BLINK/ACTIVITY modes, with mode writes applied on blink ticks.
// Optional LED_BLINK_SYNC_EN adds a 2-flop synchronizer on the blink input.
module led_blink_sched #(
  parameter int unsigned NUM_LEDS   = 4,
  parameter int unsigned HOLD_TICKS = 2,
  localparam int unsigned IDX_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                blink,
  input  logic [NUM_LEDS-1:0] activity,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [IDX_W-1:0]    cfg_led,
  input  logic [1:0]          cfg_mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick
);

  typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_ACT} mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DARK, ST_LIT} state_t;

  logic                b_in;
  logic                b_q;
  logic                b_d;

  mode_t               mode_q  [NUM_LEDS];
  mode_t               mode_n  [NUM_LEDS];
  state_t              state_q [NUM_LEDS];
  state_t              state_n [NUM_LEDS];
  logic [7:0]          cnt_q   [NUM_LEDS];
  logic [7:0]          cnt_n   [NUM_LEDS];
  logic [NUM_LEDS-1:0] flag_q;
  logic [NUM_LEDS-1:0] flag_n;
  logic [NUM_LEDS-1:0] led_n;

  logic                pend_q;
  logic [IDX_W-1:0]    pend_led_q;
  mode_t               pend_mode_q;
  logic                take;

`ifdef LED_BLINK_SYNC_EN
  logic blink_p0;
  logic blink_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_p0 <= 1'b0;
      blink_p1 <= 1'b0;
    end else begin
      blink_p0 <= blink;
      blink_p1 <= blink_p0;
    end
  end

  assign b_in = blink_p1;
`else
  assign b_in = blink;
`endif

  // Blink sampling and tick edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_q  <= 1'b0;
      b_d  <= 1'b0;
      tick <= 1'b0;
    end else begin
      b_q  <= b_in;
      b_d  <= b_q;
      tick <= b_q & ~b_d;
    end
  end

  assign take = cfg_valid && cfg_ready && (32'(cfg_led) < NUM_LEDS);

  // Next-state: activity FSMs first, then a pending mode write overrides the addressed LED
  always_comb begin
    flag_n = flag_q;
    led_n  = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      mode_n[i]  = mode_q[i];
      state_n[i] = state_q[i];
      cnt_n[i]   = cnt_q[i];
      if (mode_q[i] == MODE_ACT) begin
        case (state_q[i])
          ST_IDLE: begin
            if (activity[i]) state_n[i] = ST_WAIT;
          end
          ST_WAIT: begin
            if (activity[i]) flag_n[i] = 1'b1;
            if (tick) begin
              state_n[i] = ST_DARK;
              cnt_n[i]   = 8'(HOLD_TICKS);
            end
          end
          ST_DARK: begin
            if (activity[i]) flag_n[i] = 1'b1;
            if (tick) begin
              cnt_n[i] = cnt_q[i] - 8'd1;
              if (cnt_q[i] == 8'd1) state_n[i] = ST_LIT;
            end
          end
          default: begin
            if (tick) begin
              state_n[i] = (flag_q[i] || activity[i]) ? ST_WAIT : ST_IDLE;
              flag_n[i]  = 1'b0;
            end else if (activity[i]) begin
              flag_n[i] = 1'b1;
            end
          end
        endcase
      end
      if (pend_q && tick && (pend_led_q == IDX_W'(i))) begin
        mode_n[i]  = pend_mode_q;
        state_n[i] = ST_IDLE;
        cnt_n[i]   = 8'd0;
        flag_n[i]  = 1'b0;
      end
      case (mode_n[i])
        MODE_OFF:   led_n[i] = 1'b0;
        MODE_ON:    led_n[i] = 1'b1;
        MODE_BLINK: led_n[i] = b_q;
        default:    led_n[i] = (state_n[i] != ST_DARK);
      endcase
    end
  end

  // State registers, LED drive and the single-entry write buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i]  <= MODE_OFF;
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= 8'd0;
      end
      flag_q      <= '0;
      led         <= '0;
      pend_q      <= 1'b0;
      pend_led_q  <= '0;
      pend_mode_q <= MODE_OFF;
      cfg_ready   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i]  <= mode_n[i];
        state_q[i] <= state_n[i];
        cnt_q[i]   <= cnt_n[i];
      end
      flag_q <= flag_n;
      led    <= led_n;
      if (take) begin
        pend_q      <= 1'b1;
        pend_led_q  <= cfg_led;
        pend_mode_q <= mode_t'(cfg_mode);
        cfg_ready   <= 1'b0;
      end else begin
        pend_q    <= pend_q & ~tick;
        cfg_ready <= ~pend_q | tick;
      end
    end
  end

endmodule
